// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

   // Counting mode held in the mode register.
   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   // Period counter direction.
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Upper bounds for the duty-extraction helper; callers zero-extend into these.
   localparam int DUTY_MAX_W     = 32;
   localparam int DUTY_BUS_MAX_W = 512;

   // Return the w-bit duty field of channel ch from a packed duty bus, zero-extended.
   function automatic logic [DUTY_MAX_W-1:0] duty_of(
      input logic [DUTY_BUS_MAX_W-1:0] bus,
      input int                        ch,
      input int                        w
   );
      logic [DUTY_MAX_W-1:0] res;
      res = {DUTY_MAX_W{1'b0}};
      for (int b = 0; b < DUTY_MAX_W; b++) begin
         if (b < w) begin
            res[b] = bus[ch * w + b];
         end else begin
            res[b] = 1'b0;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Software-facing bus of the PWM block: duty/mode programming, handshake and outputs.
interface pwm_multi_if #(
   parameter int CHANNELS   = 4,
   parameter int R          = 8,
   parameter int TIMER_BITS = 15
);

   logic [CHANNELS*(R+1)-1:0] duty;
   logic [TIMER_BITS-1:0]     final_value;
   logic                      center_mode;
   logic                      ready;
   logic                      done;
   logic                      period_start;
   logic [CHANNELS-1:0]       pwm_out;

   // Driver side (software / DMA / testbench).
   modport master (
      output duty,
      output final_value,
      output center_mode,
      output ready,
      input  done,
      input  period_start,
      input  pwm_out
   );

   // PWM block side.
   modport slave (
      input  duty,
      input  final_value,
      input  center_mode,
      input  ready,
      output done,
      output period_start,
      output pwm_out
   );

endinterface

// File: rtl/pwm_prescaler.sv
// Free-running prescaler: emits a one-clock step every final_value+1 clocks.
// A terminal count lowered below the running count steps at once, never wrapping.
module pwm_prescaler #(
   parameter int TIMER_BITS = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [TIMER_BITS-1:0] final_value,
   output logic                  step
);

   localparam logic [TIMER_BITS-1:0] CNT_ZERO = {TIMER_BITS{1'b0}};
   localparam logic [TIMER_BITS-1:0] CNT_ONE  = TIMER_BITS'(1);

   logic [TIMER_BITS-1:0] count_q;
   logic [TIMER_BITS-1:0] count_d;

   // Terminal-count compare uses >= so a shrinking final_value cannot cause a long stall.
   always_comb begin
      if (count_q >= final_value) begin
         step    = 1'b1;
         count_d = CNT_ZERO;
      end else begin
         step    = 1'b0;
         count_d = count_q + CNT_ONE;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= CNT_ZERO;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel duty compare,
// edge- or center-aligned counting, duty/mode changes applied only at period boundaries.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int R          = 8,
   parameter int TIMER_BITS = 15
) (
   input  logic       clk,
   input  logic       reset,
   pwm_multi_if.slave bus
);

   localparam logic [R-1:0] Q_ZERO = {R{1'b0}};
   localparam logic [R-1:0] Q_ONE  = R'(1);
   localparam logic [R-1:0] Q_MAX  = {R{1'b1}};

   logic         step;
   logic [R-1:0] q_q;
   logic [R-1:0] q_d;
   logic [R-1:0] q_next;
   logic         dir_q;
   logic         dir_d;
   logic         mode_q;
   logic         mode_d;
   logic         done_q;
   logic         done_d;
   logic         period_start_q;
   logic         period_start_d;
   logic         boundary;
   logic         load;

   logic [DUTY_BUS_MAX_W-1:0] duty_bus_wide;

   pwm_prescaler #(
      .TIMER_BITS (TIMER_BITS)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .final_value (bus.final_value),
      .step        (step)
   );

   // Count value the period counter would take on the next step.
   always_comb begin
      if ((mode_q == MODE_CENTER) && (dir_q == DIR_DOWN)) begin
         q_next = q_q - Q_ONE;
      end else begin
         q_next = q_q + Q_ONE;
      end
   end

   // Both modes return to zero exactly once per period, so that marks the boundary.
   assign boundary = step && (q_next == Q_ZERO);
   assign load     = boundary && bus.ready;

   // Period counter, direction, mode register and boundary strobes.
   always_comb begin
      q_d            = q_q;
      dir_d          = dir_q;
      mode_d         = mode_q;
      done_d         = 1'b0;
      period_start_d = 1'b0;
      if (step) begin
         q_d = q_next;
         if (boundary) begin
            mode_d         = bus.center_mode;
            dir_d          = DIR_UP;
            period_start_d = 1'b1;
            done_d         = bus.ready;
         end else if ((mode_q == MODE_CENTER) && (q_next == Q_MAX)) begin
            dir_d = DIR_DOWN;
         end else begin
            dir_d = dir_q;
         end
      end else begin
         q_d = q_q;
      end
   end

   // Shared counter state; reset leaves Q at all ones so the first step is a boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q            <= Q_MAX;
         dir_q          <= DIR_UP;
         mode_q         <= MODE_EDGE;
         done_q         <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         q_q            <= q_d;
         dir_q          <= dir_d;
         mode_q         <= mode_d;
         done_q         <= done_d;
         period_start_q <= period_start_d;
      end
   end

   assign bus.done         = done_q;
   assign bus.period_start = period_start_q;

   assign duty_bus_wide = DUTY_BUS_MAX_W'(bus.duty);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [DUTY_MAX_W-1:0] duty_wide;
      logic [R:0]            duty_in;
      logic [R:0]            duty_q;
      logic [R:0]            duty_d;
      logic                  pwm_q;
      logic                  pwm_d;
      logic                  unused_duty_hi;

      assign duty_wide      = duty_of(duty_bus_wide, i, R + 1);
      assign duty_in        = duty_wide[R:0];
      assign unused_duty_hi = ^duty_wide[DUTY_MAX_W-1:R+1];

      // A duty loaded on this boundary already governs the first count of the new period.
      always_comb begin
         if (load) begin
            duty_d = duty_in;
         end else begin
            duty_d = duty_q;
         end
         if (step) begin
            pwm_d = ({1'b0, q_next} < duty_d);
         end else begin
            pwm_d = pwm_q;
         end
      end

      // Duty shadow and registered output for this channel.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            duty_q <= {(R+1){1'b0}};
            pwm_q  <= 1'b0;
         end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
         end
      end

      assign bus.pwm_out[i] = pwm_q;
   end

endmodule
